rot_key_cipher_pipe: RTL

//  Parametrised multi-key rotating-XOR stream cipher with a valid/ready interface on both sides.

---
 rtl/rot_key_cipher_pipe_if.sv | 42 ++++
 rtl/rot_key_cipher_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rot_key_cipher_pipe_if.sv
// Stream and key-programming bundle for rot_key_cipher_pipe.
// The slave modport is the cipher block; the master modport is the host/bench side.
interface rot_key_cipher_pipe_if #(
  parameter int DATA_W   = 32,
  parameter int KEY_W    = 32,
  parameter int NUM_KEYS = 4,
  parameter int ROT_W    = $clog2(KEY_W),
  parameter int KSEL_W   = $clog2(NUM_KEYS)
);
  // key programming
  logic                key_wr_en;
  logic [KSEL_W-1:0]   key_wr_sel;
  logic [KEY_W-1:0]    key_wr_data;
  logic [NUM_KEYS-1:0] key_loaded;

  // input stream
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [ROT_W-1:0]    in_rot;
  logic [KSEL_W-1:0]   in_ksel;

  // output stream
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_err;

  modport slave (
    input  key_wr_en, key_wr_sel, key_wr_data,
    input  in_valid, in_data, in_rot, in_ksel,
    input  out_ready,
    output key_loaded, in_ready, out_valid, out_data, out_err
  );

  modport master (
    output key_wr_en, key_wr_sel, key_wr_data,
    output in_valid, in_data, in_rot, in_ksel,
    output out_ready,
    input  key_loaded, in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/rot_key_cipher_pipe.sv
// rot_key_cipher_pipe: multi-key rotating-XOR stream cipher, two-stage valid/ready pipeline.
// Each accepted word is XORed with the low DATA_W bits of its selected key slot rotated left.
// Optional feature macro: ROLLING_ROT_EN adds a per-slot rotation counter that advances the
// effective rotation by one on every word accepted for that slot.
module rot_key_cipher_pipe #(
  parameter int DATA_W   = 32,
  parameter int KEY_W    = 32,
  parameter int NUM_KEYS = 4,
  parameter int ROT_W    = $clog2(KEY_W),
  parameter int KSEL_W   = $clog2(NUM_KEYS)
) (
  input logic               clk,
  input logic               reset,
  rot_key_cipher_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_HALF  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t occ_q, occ_d;

  // key slots, exposed per slot from the generate below
  logic [KEY_W-1:0]    slot_key    [NUM_KEYS];
  logic [NUM_KEYS-1:0] slot_loaded;
`ifdef ROLLING_ROT_EN
  logic [ROT_W-1:0]    slot_cnt    [NUM_KEYS];
`endif

  // selected-slot view for the word being offered
  logic [KEY_W-1:0]  sel_key;
  logic              sel_loaded;
  logic [ROT_W-1:0]  sel_cnt;
  logic [ROT_W-1:0]  rot_eff;
  logic [KEY_W-1:0]  rot_key;

  // pipeline registers
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [DATA_W-1:0] s1_key_q;
  logic              s1_err_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_err_q;

  // handshake
  logic in_ready;
  logic accept;
  logic drain;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid_q || bus.out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  // Only a full, stalled pipe refuses input; FULL implies both stages hold a word.
  assign in_ready = (occ_q != OCC_FULL) || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign drain    = out_valid_q && bus.out_ready;

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_err    = out_err_q;
  assign bus.key_loaded = slot_loaded;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_slot
      logic             wr_hit;
      logic [KEY_W-1:0] key_q;
      logic             loaded_q;

      assign wr_hit = bus.key_wr_en && (bus.key_wr_sel == KSEL_W'(gi));

      // Key slot storage; a write lands after the edge, so a same-cycle accept sees the old key.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          key_q    <= '0;
          loaded_q <= 1'b0;
        end else if (wr_hit) begin
          key_q    <= bus.key_wr_data;
          loaded_q <= 1'b1;
        end
      end

      assign slot_key[gi]    = key_q;
      assign slot_loaded[gi] = loaded_q;

`ifdef ROLLING_ROT_EN
      logic [ROT_W-1:0] cnt_q;

      // Rolling rotation counter; a key rewrite restarts the sequence and beats a same-cycle accept.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
        end else if (wr_hit) begin
          cnt_q <= '0;
        end else if (accept && (bus.in_ksel == KSEL_W'(gi))) begin
          cnt_q <= cnt_q + ROT_W'(1);
        end
      end

      assign slot_cnt[gi] = cnt_q;
`endif
    end
  endgenerate

  // Select the addressed slot; an out-of-range select reads as an unprogrammed zero key.
  always_comb begin
    sel_key    = '0;
    sel_loaded = 1'b0;
    sel_cnt    = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (bus.in_ksel == KSEL_W'(k)) begin
        sel_key    = slot_key[k];
        sel_loaded = slot_loaded[k];
`ifdef ROLLING_ROT_EN
        sel_cnt    = slot_cnt[k];
`endif
      end
    end
  end

  // Effective rotation wraps modulo KEY_W for free because KEY_W is a power of two.
`ifdef ROLLING_ROT_EN
  assign rot_eff = bus.in_rot + sel_cnt;
`else
  assign rot_eff = bus.in_rot;
`endif

  // Left-rotate the selected key; zero rotation is special-cased to avoid a shift by KEY_W.
  always_comb begin
    rot_key = sel_key;
    if (rot_eff != '0) begin
      rot_key = (sel_key << rot_eff) | (sel_key >> (KEY_W - int'(rot_eff)));
    end
  end

  // Two-stage datapath: S1 snapshots word/key/err on accept, S2 produces the XOR result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_key_q    <= '0;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= bus.in_data;
        s1_key_q   <= rot_key[DATA_W-1:0];
        s1_err_q   <= !sel_loaded;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end

      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= s1_err_q ? '0 : (s1_data_q ^ s1_key_q);
          out_err_q  <= s1_err_q;
        end
      end
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= OCC_EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Occupancy next state: accept adds a word, drain removes one, both together cancel.
  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      OCC_EMPTY: if (accept) occ_d = OCC_HALF;
      OCC_HALF: begin
        if (accept && !drain)      occ_d = OCC_FULL;
        else if (drain && !accept) occ_d = OCC_EMPTY;
      end
      OCC_FULL:  if (drain && !accept) occ_d = OCC_HALF;
      default:   occ_d = OCC_EMPTY;
    endcase
  end

endmodule
